ram_1r1w_valid: RTL and testbench

RAM_1R1W_VALID -- requirements
Module: ram_1r1w_valid

---
 rtl/ram_1r1w_valid.sv | 105 ++++++++++
 tb/tb_ram_1r1w_valid.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ram_1r1w_valid.sv
// Single-clock 1-read / 1-write RAM with a per-entry valid vector and flush.
// Reads have a fixed one-cycle latency, per-lane write-first bypass, and zero data on a miss.
module ram_1r1w_valid #(
    parameter  int DEPTH     = 7,
    parameter  int WIDTH     = 1,
    parameter  int MASK_BITS = 1,
    localparam int ADDR_W    = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    R0_addr,
    input  logic                 R0_en,
    output logic [WIDTH-1:0]     R0_data,
    output logic                 R0_valid,
    output logic                 R0_hit,
    input  logic [ADDR_W-1:0]    W0_addr,
    input  logic                 W0_en,
    input  logic [WIDTH-1:0]     W0_data,
    input  logic [MASK_BITS-1:0] W0_mask,
    input  logic                 flush
);

    localparam int              LW      = WIDTH / MASK_BITS;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH - 1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;

    logic              wr_legal_s;
    logic              rd_legal_s;
    logic [ADDR_W-1:0] wr_idx_s;
    logic [ADDR_W-1:0] rd_idx_s;
    logic [WIDTH-1:0]  lane_mask_s;
    logic [DEPTH-1:0]  wr_onehot_s;
    logic [DEPTH-1:0]  valid_nxt_s;
    logic [WIDTH-1:0]  old_word_s;
    logic [WIDTH-1:0]  bypass_word_s;
    logic              same_addr_s;
    logic              hit_s;
    logic [WIDTH-1:0]  rd_word_s;

    // Address legality; out-of-range addresses are steered to entry 0 so no index leaves the array.
    always_comb begin
        wr_legal_s = W0_en && ({1'b0, W0_addr} < DEPTH_L);
        rd_legal_s = {1'b0, R0_addr} < DEPTH_L;
        wr_idx_s   = wr_legal_s ? W0_addr : {ADDR_W{1'b0}};
        rd_idx_s   = rd_legal_s ? R0_addr : {ADDR_W{1'b0}};
    end

    // Expand the per-lane write mask to a per-bit mask.
    always_comb begin
        lane_mask_s = {WIDTH{1'b0}};
        for (int i = 0; i < MASK_BITS; i++) begin
            lane_mask_s[i*LW +: LW] = {LW{W0_mask[i]}};
        end
    end

    // Next valid vector: flush clears everything, a legal write re-validates its entry on top.
    always_comb begin
        wr_onehot_s = wr_legal_s ? (ONE_HOT0 << wr_idx_s) : {DEPTH{1'b0}};
        valid_nxt_s = (flush ? {DEPTH{1'b0}} : valid_r) | wr_onehot_s;
    end

    // Read path: a same-edge write to the read address wins lane by lane; misses return zero.
    always_comb begin
        old_word_s    = mem_r[rd_idx_s];
        bypass_word_s = (old_word_s & ~lane_mask_s) | (W0_data & lane_mask_s);
        same_addr_s   = wr_legal_s && rd_legal_s && (W0_addr == R0_addr);
        hit_s         = rd_legal_s && (valid_r[rd_idx_s] || same_addr_s);
        rd_word_s     = hit_s ? (same_addr_s ? bypass_word_s : old_word_s) : {WIDTH{1'b0}};
    end

    // Storage array: deliberately not reset, writes blocked while reset is held.
    always_ff @(posedge clock) begin
        if (reset_n && wr_legal_s) begin
            mem_r[wr_idx_s] <= (mem_r[wr_idx_s] & ~lane_mask_s) | (W0_data & lane_mask_s);
        end
    end

    // Valid vector register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= {DEPTH{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
        end
    end

    // Registered read response; data and hit hold their last value between responses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            R0_valid <= 1'b0;
            R0_hit   <= 1'b0;
            R0_data  <= {WIDTH{1'b0}};
        end else begin
            R0_valid <= R0_en;
            if (R0_en) begin
                R0_hit  <= hit_s;
                R0_data <= rd_word_s;
            end
        end
    end

endmodule

// File: tb/tb_ram_1r1w_valid.sv
// Directed self-checking bench for ram_1r1w_valid with DEPTH=7, WIDTH=8, MASK_BITS=2.
module tb_ram_1r1w_valid;

    localparam int DEPTH     = 7;
    localparam int WIDTH     = 8;
    localparam int MASK_BITS = 2;
    localparam int ADDR_W    = 3;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [ADDR_W-1:0]    R0_addr;
    logic                 R0_en;
    logic [WIDTH-1:0]     R0_data;
    logic                 R0_valid;
    logic                 R0_hit;
    logic [ADDR_W-1:0]    W0_addr;
    logic                 W0_en;
    logic [WIDTH-1:0]     W0_data;
    logic [MASK_BITS-1:0] W0_mask;
    logic                 flush;

    int n_checks = 0;
    int n_errors = 0;

    ram_1r1w_valid #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_BITS(MASK_BITS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .R0_addr (R0_addr),
        .R0_en   (R0_en),
        .R0_data (R0_data),
        .R0_valid(R0_valid),
        .R0_hit  (R0_hit),
        .W0_addr (W0_addr),
        .W0_en   (W0_en),
        .W0_data (W0_data),
        .W0_mask (W0_mask),
        .flush   (flush)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic v, input logic h, input logic [7:0] d);
        chk({tag, ".valid"}, {7'd0, R0_valid}, {7'd0, v});
        chk({tag, ".hit"},   {7'd0, R0_hit},   {7'd0, h});
        chk({tag, ".data"},  R0_data, d);
    endtask

    // Apply one cycle of inputs, let one rising edge sample them, then settle past the edge.
    task automatic cyc(input logic ren, input logic [2:0] ra, input logic wen, input logic [2:0] wa,
                       input logic [7:0] wd, input logic [1:0] wm, input logic fl);
        R0_en   = ren;
        R0_addr = ra;
        W0_en   = wen;
        W0_addr = wa;
        W0_data = wd;
        W0_mask = wm;
        flush   = fl;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        R0_en = 1'b0; R0_addr = 3'd0;
        W0_en = 1'b0; W0_addr = 3'd0; W0_data = 8'h00; W0_mask = 2'b00;
        flush = 1'b0;
        #2;
        chk_resp("reset", 1'b0, 1'b0, 8'h00);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        cyc(1'b1, 3'd3, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd3_empty", 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk("idle_valid", {7'd0, R0_valid}, 8'h00);

        cyc(1'b0, 3'd0, 1'b1, 3'd6, 8'hA5, 2'b11, 1'b0);
        cyc(1'b1, 3'd6, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd6", 1'b1, 1'b1, 8'hA5);
        cyc(1'b1, 3'd7, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd7_oob", 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 3'd6, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd6_again", 1'b1, 1'b1, 8'hA5);
        cyc(1'b0, 3'd1, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("hold", 1'b0, 1'b1, 8'hA5);

        cyc(1'b0, 3'd0, 1'b1, 3'd2, 8'h3C, 2'b11, 1'b0);
        cyc(1'b1, 3'd2, 1'b1, 3'd2, 8'hF0, 2'b10, 1'b0);
        chk_resp("bypass_lane", 1'b1, 1'b1, 8'hFC);
        cyc(1'b1, 3'd2, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd2_merged", 1'b1, 1'b1, 8'hFC);

        cyc(1'b0, 3'd0, 1'b1, 3'd1, 8'h22, 2'b11, 1'b0);
        cyc(1'b0, 3'd0, 1'b1, 3'd4, 8'h44, 2'b11, 1'b0);
        cyc(1'b0, 3'd0, 1'b1, 3'd5, 8'h77, 2'b11, 1'b0);
        cyc(1'b1, 3'd1, 1'b1, 3'd4, 8'h11, 2'b11, 1'b1);
        chk_resp("flush_same_edge", 1'b1, 1'b1, 8'h22);
        cyc(1'b1, 3'd1, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd1_flushed", 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 3'd4, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd4_write_wins", 1'b1, 1'b1, 8'h11);
        cyc(1'b1, 3'd5, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd5_flushed", 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 3'd0, 1'b1, 3'd5, 8'h00, 2'b00, 1'b0);
        cyc(1'b1, 3'd5, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd5_mask0_valid", 1'b1, 1'b1, 8'h77);

        cyc(1'b0, 3'd0, 1'b1, 3'd7, 8'hFF, 2'b11, 1'b1);
        cyc(1'b1, 3'd4, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd4_after_oob_flush", 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 3'd7, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd7_after_oob_write", 1'b1, 1'b0, 8'h00);

        cyc(1'b0, 3'd0, 1'b1, 3'd4, 8'h11, 2'b11, 1'b0);
        cyc(1'b1, 3'd4, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd4_pre_reset", 1'b1, 1'b1, 8'h11);
        R0_en   = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_resp("async_reset", 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 3'd0, 1'b1, 3'd0, 8'h99, 2'b11, 1'b0);
        chk_resp("in_reset_req", 1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("post_release", 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 3'd0, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd0_write_in_reset_ignored", 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 3'd4, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk_resp("rd4_valid_cleared", 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 3'd0, 1'b1, 3'(i), 8'(8'h10 + i), 2'b11, 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 3'(i), 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
            chk_resp($sformatf("b2b_rd%0d", i), 1'b1, 1'b1, 8'(8'h10 + i));
        end
        cyc(1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 2'b00, 1'b0);
        chk("b2b_end_valid", {7'd0, R0_valid}, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
